pipe_stage_hs: RTL and testbench

- Parametrised pipeline stage register: the generalised replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle of configurable width between two stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, giving full throughput and a registered in_ready.
- Distinguishes stall (hold contents) from flush (insert bubble); a single pause that zeroes contents is not used.

---
 rtl/pipe_stage_hs.sv | 85 ++++++++
 tb/tb_pipe_stage_hs.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage register with a 2-entry skid buffer, stall and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush event counters.
module pipe_stage_hs #(
    parameter int                 CTRL_W   = 16,
    parameter int                 DATA_W   = 128,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              acc, pop, load_in, load_skid, shift;

    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign load_in   = acc & (~main_valid | pop);
    assign load_skid = acc & main_valid & ~pop;
    assign shift     = skid_valid & pop;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_RST;
    assign out_data  = main_valid ? main_data : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Valid bits depend only on handshake signals, so payload X never reaches them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= acc | skid_valid | (main_valid & ~pop);
            skid_valid <= skid_valid ? ~pop : load_skid;
        end
    end

    // Payload needs no reset: outputs are masked while the entry is invalid.
    always_ff @(posedge clk) begin
        if (shift) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end else if (load_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end
        if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && occupancy != 2'd0 && flush_cnt != '1)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed self-checking bench for pipe_stage_hs.
module tb_pipe_stage_hs;
    logic         clk = 0;
    logic         rst = 0;
    logic         flush = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [15:0]  in_ctrl = '0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [15:0]  out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
    int           n_checks = 0;
    int           n_fail = 0;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt, flush_cnt;
`endif

    pipe_stage_hs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[15:0] ^ 16'h8000;
        out_ready = r;
    endtask

    initial begin
        #2;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_occ", 128'(occupancy), 128'd0);
        check("rst_ctrl", 128'(out_ctrl), 128'd0);
        check("rst_data", out_data, 128'd0);
        #5 rst = 1;
        step();

        for (int i = 0; i < 8; i++) begin
            drive(1, 128'(i), 1);
            step();
            check("stream_valid", 128'(out_valid), 128'd1);
            check("stream_data", out_data, 128'(i));
            check("stream_ctrl", 128'(out_ctrl), 128'(16'(i) ^ 16'h8000));
            check("stream_in_ready", 128'(in_ready), 128'd1);
        end
        drive(0, 128'hdead, 1);
        step();
        check("drain_valid", 128'(out_valid), 128'd0);
        check("drain_data", out_data, 128'd0);
        check("drain_occ", 128'(occupancy), 128'd0);

        drive(1, 128'hA, 0);
        step();
        check("bp_occ1", 128'(occupancy), 128'd1);
        check("bp_dataA", out_data, 128'hA);
        drive(1, 128'hB, 0);
        step();
        check("bp_occ2", 128'(occupancy), 128'd2);
        check("bp_in_ready0", 128'(in_ready), 128'd0);
        check("bp_holdA", out_data, 128'hA);
        drive(1, 128'hC, 0);
        step();
        check("bp_stall_data", out_data, 128'hA);
        check("bp_stall_occ", 128'(occupancy), 128'd2);
        drive(0, 128'h0, 1);
        step();
        check("bp_dataB", out_data, 128'hB);
        check("bp_in_ready1", 128'(in_ready), 128'd1);
        check("bp_occ_after", 128'(occupancy), 128'd1);
        step();
        check("bp_empty", 128'(out_valid), 128'd0);

        drive(1, 128'h11, 0);
        step();
        drive(1, 128'h22, 0);
        step();
        check("fl_occ2", 128'(occupancy), 128'd2);
        drive(0, 128'h0, 0);
        flush = 1;
        step();
        flush = 0;
        check("fl_valid", 128'(out_valid), 128'd0);
        check("fl_ctrl", 128'(out_ctrl), 128'd0);
        check("fl_data", out_data, 128'd0);
        check("fl_occ", 128'(occupancy), 128'd0);
        check("fl_in_ready", 128'(in_ready), 128'd1);

        drive(1, 128'h55, 1);
        flush = 1;
        step();
        flush = 0;
        drive(0, 128'h0, 1);
        check("fla_valid", 128'(out_valid), 128'd0);
        check("fla_occ", 128'(occupancy), 128'd0);
        check("fla_data", out_data, 128'd0);
        step();
        check("fla_valid2", 128'(out_valid), 128'd0);

        drive(1, 128'h66, 0);
        step();
        drive(1, 128'h77, 0);
        step();
        drive(0, 128'h0, 0);
        check("mr_occ2", 128'(occupancy), 128'd2);
        #2 rst = 0;
        #1;
        check("mr_valid", 128'(out_valid), 128'd0);
        check("mr_in_ready", 128'(in_ready), 128'd1);
        check("mr_ctrl", 128'(out_ctrl), 128'd0);
        check("mr_occ", 128'(occupancy), 128'd0);
        #2 rst = 1;
        step();
        check("mr_after", 128'(out_valid), 128'd0);

`ifdef PIPE_STAGE_PERF_EN
        check("perf_rst_stall", 128'(stall_cnt), 128'd0);
        drive(1, 128'h88, 0);
        step();
        drive(0, 128'h0, 0);
        for (int i = 0; i < 5; i++) step();
        check("perf_stall5", 128'(stall_cnt), 128'd5);
        out_ready = 1;
        flush = 1;
        step();
        flush = 0;
        check("perf_stall", 128'(stall_cnt), 128'd5);
        check("perf_flush", 128'(flush_cnt), 128'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
